clk_div_bank: RTL
=================

Name: clk_div_bank

Overview:
- Parametrised bank of NUM_CH independent integer clock dividers clocked from the main clock.
- Successor to the fixed two-output clock manager. Divisors are programmable at run time, and updates take effect glitch-free at period boundaries.
- Each channel has an enable with no runt pulses on stop, a one-cycle tick (clock-enable) output, and a global phase re-sync.
- Feeds DUT/ADC/sample-rate clock domains and clock-enable logic.

Parameters:
- NUM_CH, 4: number of divider channels (1..16).
- DIV_W, 8: divisor and counter width. Legal divisor range is 2..2^DIV_W-1.
- CH_W, 2: channel-select width, max(1, clog2(NUM_CH)). Must be set consistently with NUM_CH.
- DEF_DIV, 4: divisor loaded into every channel at reset. Must be ≥2.

Ports:
- clk_in, input, 1: main clock, 100MHz.
- rst_n, input, 1: synchronous reset, active-low; sampled on posedge clk_in.
- ch_en, input, NUM_CH: per-channel run enable, level.
- cfg_valid, input, 1: config write request.
- cfg_ch, input, CH_W: target channel.
- cfg_div, input, DIV_W: new divisor.
- cfg_ready, output, 1: combinational; high when the write can be accepted.
- cfg_err, output, 1: one-cycle pulse on a rejected write.
- sync_req, input, 1: single-cycle request to phase-align all running channels.
- clk_div_out, output, NUM_CH: divided clocks, registered.
- tick, output, NUM_CH: one-cycle pulse on the first cycle of each period, registered.
- running, output, NUM_CH: channel state != IDLE.
- cnt_dbg, output, NUM_CH*DIV_W: per-channel counter; channel i occupies bits [i*DIV_W +: DIV_W].

Behaviour:
- Reset (rst_n=0 at posedge), all channels:
  - state=IDLE, cnt=0, div_act=shadow=DEF_DIV, pending=0.
  - clk_div_out=0, tick=0, cfg_err=0.
  - Reset mid-operation truncates outputs at that edge; this is the only permitted runt.
- Per-channel FSM, states IDLE / RUN / STOPPING.
  - IDLE: output 0, cnt=0. When ch_en=1 → RUN; on that edge nxt=0, so out=1 and tick=1.
  - RUN:
    - nxt = (cnt==div_act-1) ? 0 : cnt+1. cnt<=nxt.
    - clk_div_out <= (nxt < HI), where HI = div_act - (div_act>>1), i.e. high for ceil(N/2) cycles.
    - tick <= (nxt==0).
    - ch_en=0 → STOPPING, counting continues unchanged.
  - STOPPING: counts as in RUN.
    - ch_en=1 → RUN, with no disturbance to the output.
    - At the wrap edge (nxt==0) → IDLE with out=0, tick=0, cnt=0.
    - The final period always completes fully.
- Wrap edge: the edge where nxt==0. If pending, div_act<=shadow and pending<=0; the new period uses the new divisor.
- Config handshake:
  - cfg_ready = (cfg_ch≥NUM_CH) | !pending[cfg_ch].
  - Accept when cfg_valid & cfg_ready.
  - Rejection: if cfg_div<2 or cfg_ch≥NUM_CH, cfg_err<=1 for one cycle and no state changes.
  - Target IDLE: div_act<=cfg_div directly; pending stays 0.
  - Target RUN/STOPPING: shadow<=cfg_div, pending<=1.
  - A write accepted on a wrap edge takes effect at the following wrap.
- sync_req=1: every non-IDLE channel treats that edge as a wrap.
  - Effects: nxt=0, pending applied, RUN→out=1/tick=1, STOPPING→IDLE.
  - sync_req has priority over normal counting. IDLE channels are unaffected.
- Simultaneous ch_en rise and config write to the same IDLE channel: the channel starts with the new divisor.
- Divisor 2 gives out=1,0 and a tick every cycle pair. Divisor 2^DIV_W-1 must count without overflow.

Test Plan:
1. Reset, then ch_en[0]=1 with DEF_DIV=4 → clk_div_out[0] = 1,1,0,0 repeating; tick[0] on cycles 0,4,8; running[0]=1; other channels 0.
2. Write ch1 div=5 while IDLE, then enable → high 3 cycles, low 2; cnt_dbg ch1 cycles 0..4.
3. ch0 running div=4, write div=6 at cnt=1 → cfg_ready low for ch0 until wrap; current period stays 4 cycles, subsequent periods 3 high / 3 low; a second write during pending is blocked.
4. ch0 div=4, drop ch_en at cnt=1 → output finishes 1,0,0, then IDLE, running falls at wrap; no high pulse shorter than 2 cycles. Re-raise ch_en during STOPPING → continuous output.
5. NUM_CH=3: write cfg_div=1, then cfg_ch=3 → cfg_err one-cycle pulse each; divisors unchanged; cfg_ready=1.
6. ch0 div=4, ch1 div=6 at arbitrary phases, pulse sync_req → next cycle both cnt=0, out=1, tick=1. Assert rst_n=0 mid-high → all outputs 0 on the following edge.

Source files
------------

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH run-time programmable integer clock dividers with glitch-free
// divisor updates at period boundaries, clean stop, tick outputs and phase re-sync.
module clk_div_bank #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned CH_W    = 2,
    parameter int unsigned DEF_DIV = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic                     cfg_valid,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [DIV_W-1:0]         cfg_div,
    output logic                     cfg_ready,
    output logic                     cfg_err,
    input  logic                     sync_req,
    output logic [NUM_CH-1:0]        clk_div_out,
    output logic [NUM_CH-1:0]        tick,
    output logic [NUM_CH-1:0]        running,
    output logic [NUM_CH*DIV_W-1:0]  cnt_dbg
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } ch_state_e;

    ch_state_e          state_q  [NUM_CH];
    logic [DIV_W-1:0]   cnt_q    [NUM_CH];
    logic [DIV_W-1:0]   div_q    [NUM_CH];
    logic [DIV_W-1:0]   shadow_q [NUM_CH];
    logic [NUM_CH-1:0]  pending_q;
    logic [NUM_CH-1:0]  out_q;
    logic [NUM_CH-1:0]  tick_q;
    logic               err_q;

    logic [DIV_W-1:0]   cnt_d    [NUM_CH];
    logic [DIV_W-1:0]   hi_c     [NUM_CH];
    logic [NUM_CH-1:0]  wrap_c;
    logic [NUM_CH-1:0]  wr_hit_c;
    logic               ch_ok_c;
    logic               div_ok_c;
    logic               accept_c;
    logic               wr_ok_c;
    logic               wr_err_c;

    // Config handshake decode; out-of-range channels are always ready so they can be rejected.
    always_comb begin
        ch_ok_c   = {1'b0, cfg_ch} < (CH_W+1)'(NUM_CH);
        div_ok_c  = cfg_div >= DIV_W'(2);
        cfg_ready = ch_ok_c ? !pending_q[cfg_ch] : 1'b1;
        accept_c  = cfg_valid & cfg_ready;
        wr_ok_c   = accept_c & ch_ok_c & div_ok_c;
        wr_err_c  = accept_c & !(ch_ok_c & div_ok_c);
    end

    // Per-channel counter next value; sync_req forces a wrap on every active channel.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit_c[i] = wr_ok_c && ({1'b0, cfg_ch} == (CH_W+1)'(i));
            wrap_c[i]   = sync_req || (cnt_q[i] == div_q[i] - DIV_W'(1));
            cnt_d[i]    = wrap_c[i] ? '0 : cnt_q[i] + DIV_W'(1);
            hi_c[i]     = div_q[i] - (div_q[i] >> 1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= IDLE;
                cnt_q[i]    <= '0;
                div_q[i]    <= DIV_W'(DEF_DIV);
                shadow_q[i] <= DIV_W'(DEF_DIV);
            end
            pending_q <= '0;
            out_q     <= '0;
            tick_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= wr_err_c;
            for (int i = 0; i < NUM_CH; i++) begin
                case (state_q[i])
                    IDLE: begin
                        cnt_q[i] <= '0;
                        // An update left pending by a stop-wrap write folds in while idle
                        if (pending_q[i]) begin
                            div_q[i]     <= shadow_q[i];
                            pending_q[i] <= 1'b0;
                        end
                        if (wr_hit_c[i]) begin
                            div_q[i] <= cfg_div;
                        end
                        out_q[i]  <= ch_en[i];
                        tick_q[i] <= ch_en[i];
                        if (ch_en[i]) begin
                            state_q[i] <= RUN;
                        end
                    end
                    default: begin
                        if (wrap_c[i] && pending_q[i]) begin
                            div_q[i]     <= shadow_q[i];
                            pending_q[i] <= 1'b0;
                        end
                        if (wr_hit_c[i]) begin
                            shadow_q[i]  <= cfg_div;
                            pending_q[i] <= 1'b1;
                        end
                        if (state_q[i] == STOPPING && !ch_en[i] && wrap_c[i]) begin
                            state_q[i] <= IDLE;
                            cnt_q[i]   <= '0;
                            out_q[i]   <= 1'b0;
                            tick_q[i]  <= 1'b0;
                        end else begin
                            state_q[i] <= ch_en[i] ? RUN : STOPPING;
                            cnt_q[i]   <= cnt_d[i];
                            out_q[i]   <= cnt_d[i] < hi_c[i];
                            tick_q[i]  <= wrap_c[i];
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            running[i]                   = state_q[i] != IDLE;
            cnt_dbg[i*DIV_W +: DIV_W]    = cnt_q[i];
        end
    end

    assign clk_div_out = out_q;
    assign tick        = tick_q;
    assign cfg_err     = err_q;

endmodule
